// File: rtl/alu_commit.sv
// Commit stage behind the BPF ALU: captures instruction context, acks the ALU result,
// resolves jumps or A write-back into a single commit beat. Option macro: ALU_COMMIT_TRAP_EN.
module alu_commit #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_vld,
    output logic             op_rdy,
    input  logic             op_jmp,
    input  logic [1:0]       op_cond,
    input  logic [3:0]       op_sel,
    input  logic [PC_W-1:0]  op_pc,
    input  logic [OFF_W-1:0] op_jt,
    input  logic [OFF_W-1:0] op_jf,
    input  logic [31:0]      ALU_out,
    input  logic             eq,
    input  logic             gt,
    input  logic             ge,
    input  logic             set,
    input  logic             ALU_vld,
    output logic             ALU_ack,
    output logic             commit_vld,
    input  logic             commit_rdy,
    output logic             A_wr_en,
    output logic [31:0]      A_wr_data,
    output logic [PC_W-1:0]  pc_next,
    output logic             taken,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_t;

    state_t state, state_nxt;

    logic             ctx_jmp;
    logic [1:0]       ctx_cond;
    logic [PC_W-1:0]  ctx_pc;
    logic [OFF_W-1:0] ctx_jt;
    logic [OFF_W-1:0] ctx_jf;

    logic             capture;
    logic             resolve;
    logic             release_beat;
    logic             flag;
    logic             taken_n;
    logic [OFF_W-1:0] offset;
    logic [PC_W-1:0]  pc_n;
    logic             trap;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        op_rdy       = 1'b0;
        ALU_ack      = 1'b0;
        capture      = 1'b0;
        resolve      = 1'b0;
        release_beat = 1'b0;
        case (state)
            IDLE: begin
                op_rdy = 1'b1;
                if (op_vld) begin
                    capture   = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                ALU_ack = ALU_vld;
                if (ALU_vld) begin
                    resolve   = 1'b1;
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                if (commit_rdy) begin
                    release_beat = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctx_jmp  <= 1'b0;
            ctx_cond <= 2'd0;
            ctx_pc   <= '0;
            ctx_jt   <= '0;
            ctx_jf   <= '0;
        end else if (capture) begin
            ctx_jmp  <= op_jmp;
            ctx_cond <= op_cond;
            ctx_pc   <= op_pc;
            ctx_jt   <= op_jt;
            ctx_jf   <= op_jf;
        end
    end

    // Offsets are zero-extended into the PC width; the sum wraps naturally.
    always_comb begin
        case (ctx_cond)
            2'd0:    flag = eq;
            2'd1:    flag = gt;
            2'd2:    flag = ge;
            default: flag = set;
        endcase
        taken_n = ctx_jmp & flag;
        offset  = taken_n ? ctx_jt : ctx_jf;
        if (ctx_jmp) pc_n = ctx_pc + PC_W'(1) + PC_W'(offset);
        else         pc_n = ctx_pc + PC_W'(1);
    end

`ifdef ALU_COMMIT_TRAP_EN
    logic [3:0] ctx_sel;
    logic       err_r;

    always_ff @(posedge clk) begin
        if (rst)          ctx_sel <= 4'd0;
        else if (capture) ctx_sel <= op_sel;
    end

    // mul/div/mod are unsupported by the ALU, so their results trap instead of reaching A.
    assign trap = ~ctx_jmp & ((ctx_sel == 4'd2) | (ctx_sel == 4'd3) | (ctx_sel == 4'd9));
    assign err  = err_r;
`else
    logic sel_unused;

    assign sel_unused = ^op_sel;
    assign trap       = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_vld <= 1'b0;
            A_wr_en    <= 1'b0;
            A_wr_data  <= 32'd0;
            pc_next    <= '0;
            taken      <= 1'b0;
`ifdef ALU_COMMIT_TRAP_EN
            err_r      <= 1'b0;
`endif
        end else if (resolve) begin
            commit_vld <= 1'b1;
            A_wr_en    <= ~ctx_jmp & ~trap;
            A_wr_data  <= ALU_out;
            pc_next    <= pc_n;
            taken      <= taken_n;
`ifdef ALU_COMMIT_TRAP_EN
            err_r      <= trap;
`endif
        end else if (release_beat) begin
            commit_vld <= 1'b0;
            A_wr_en    <= 1'b0;
            taken      <= 1'b0;
`ifdef ALU_COMMIT_TRAP_EN
            err_r      <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_alu_commit.sv
// Self-checking bench for alu_commit: directed vector table, hand-written corner
// sequences, and randomized transactions checked against a spec-level model.
module tb_alu_commit;

    localparam int PC_W  = 10;
    localparam int OFF_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             op_vld;
    logic             op_rdy;
    logic             op_jmp;
    logic [1:0]       op_cond;
    logic [3:0]       op_sel;
    logic [PC_W-1:0]  op_pc;
    logic [OFF_W-1:0] op_jt;
    logic [OFF_W-1:0] op_jf;
    logic [31:0]      ALU_out;
    logic             eq, gt, ge, set;
    logic             ALU_vld;
    logic             ALU_ack;
    logic             commit_vld;
    logic             commit_rdy;
    logic             A_wr_en;
    logic [31:0]      A_wr_data;
    logic [PC_W-1:0]  pc_next;
    logic             taken;
    logic             err;

    int checks = 0;
    int passes = 0;

    alu_commit #(.PC_W(PC_W), .OFF_W(OFF_W)) dut (
        .clk(clk), .rst(rst),
        .op_vld(op_vld), .op_rdy(op_rdy), .op_jmp(op_jmp), .op_cond(op_cond),
        .op_sel(op_sel), .op_pc(op_pc), .op_jt(op_jt), .op_jf(op_jf),
        .ALU_out(ALU_out), .eq(eq), .gt(gt), .ge(ge), .set(set),
        .ALU_vld(ALU_vld), .ALU_ack(ALU_ack),
        .commit_vld(commit_vld), .commit_rdy(commit_rdy),
        .A_wr_en(A_wr_en), .A_wr_data(A_wr_data), .pc_next(pc_next),
        .taken(taken), .err(err)
    );

    always #5 clk = ~clk;

    // flags packs the ALU predicates as {eq, gt, ge, set}
    typedef struct {
        logic        jmp;
        logic [1:0]  cond;
        logic [3:0]  sel;
        logic [9:0]  pc;
        logic [7:0]  jt;
        logic [7:0]  jf;
        logic [31:0] alu;
        logic [3:0]  flags;
        logic        exp_taken;
        logic [9:0]  exp_pc;
        logic        exp_wr;
        logic        exp_err;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    function automatic vec_t predict(input vec_t v);
        vec_t r = v;
        logic hit;
        int   off;
        case (v.cond)
            2'd0:    hit = v.flags[3];
            2'd1:    hit = v.flags[2];
            2'd2:    hit = v.flags[1];
            default: hit = v.flags[0];
        endcase
        r.exp_taken = v.jmp && hit;
        off = !v.jmp ? 0 : (r.exp_taken ? int'(v.jt) : int'(v.jf));
        r.exp_pc = 10'((int'(v.pc) + 1 + off) % (1 << PC_W));
`ifdef ALU_COMMIT_TRAP_EN
        r.exp_err = !v.jmp && (v.sel == 4'd2 || v.sel == 4'd3 || v.sel == 4'd9);
`else
        r.exp_err = 1'b0;
`endif
        r.exp_wr = !v.jmp && !r.exp_err;
        return r;
    endfunction

    task automatic applyStimulus(input vec_t v, input int waitCycles, input int holdCycles);
        @(negedge clk);
        checkOutput("op_rdy_idle", 32'(op_rdy), 32'd1);
        op_vld = 1'b1; op_jmp = v.jmp; op_cond = v.cond; op_sel = v.sel;
        op_pc = v.pc; op_jt = v.jt; op_jf = v.jf;
        @(negedge clk);
        op_vld = 1'b0;
        checkOutput("op_rdy_wait", 32'(op_rdy), 32'd0);
        checkOutput("ack_no_vld", 32'(ALU_ack), 32'd0);
        for (int w = 0; w < waitCycles; w++) begin
            @(negedge clk);
            checkOutput("commit_early", 32'(commit_vld), 32'd0);
        end
        ALU_vld = 1'b1; ALU_out = v.alu;
        {eq, gt, ge, set} = v.flags;
        #1;
        checkOutput("ack", 32'(ALU_ack), 32'd1);
        @(negedge clk);
        ALU_vld = 1'b0; ALU_out = $urandom; {eq, gt, ge, set} = 4'($urandom);
        checkOutput("commit_vld", 32'(commit_vld), 32'd1);
        checkOutput("ack_drop", 32'(ALU_ack), 32'd0);
        checkOutput("taken", 32'(taken), 32'(v.exp_taken));
        checkOutput("pc_next", 32'(pc_next), 32'(v.exp_pc));
        checkOutput("A_wr_en", 32'(A_wr_en), 32'(v.exp_wr));
        checkOutput("err", 32'(err), 32'(v.exp_err));
        if (v.exp_wr) checkOutput("A_wr_data", A_wr_data, v.alu);
        for (int h = 0; h < holdCycles; h++) begin
            op_vld = 1'b1; op_pc = 10'($urandom); op_jmp = 1'($urandom);
            @(negedge clk);
            checkOutput("hold_commit_vld", 32'(commit_vld), 32'd1);
            checkOutput("hold_op_rdy", 32'(op_rdy), 32'd0);
            checkOutput("hold_pc_next", 32'(pc_next), 32'(v.exp_pc));
            checkOutput("hold_A_wr_en", 32'(A_wr_en), 32'(v.exp_wr));
        end
        op_vld = 1'b0; commit_rdy = 1'b1;
        @(negedge clk);
        commit_rdy = 1'b0;
        checkOutput("post_commit_vld", 32'(commit_vld), 32'd0);
        checkOutput("post_op_rdy", 32'(op_rdy), 32'd1);
        checkOutput("post_A_wr_en", 32'(A_wr_en), 32'd0);
        checkOutput("post_taken", 32'(taken), 32'd0);
        checkOutput("post_err", 32'(err), 32'd0);
    endtask

    vec_t vecs[8];
    vec_t rv;

    initial begin
        // {jmp, cond, sel, pc, jt, jf, alu, flags, exp_taken, exp_pc, exp_wr, exp_err}
        vecs[0] = '{1'b0, 2'd0, 4'd0, 10'd5,    8'd0,  8'd0,   32'h12,        4'b0000, 1'b0, 10'd6,   1'b1, 1'b0};
        vecs[1] = '{1'b1, 2'd0, 4'd0, 10'd10,   8'd3,  8'd7,   32'h0,         4'b1000, 1'b1, 10'd14,  1'b0, 1'b0};
        vecs[2] = '{1'b1, 2'd0, 4'd0, 10'd10,   8'd3,  8'd7,   32'h0,         4'b0111, 1'b0, 10'd18,  1'b0, 1'b0};
        vecs[3] = '{1'b1, 2'd3, 4'd0, 10'd1020, 8'd10, 8'd0,   32'h0,         4'b0001, 1'b1, 10'd7,   1'b0, 1'b0};
        vecs[4] = '{1'b1, 2'd1, 4'd0, 10'd100,  8'd0,  8'd5,   32'h0,         4'b0100, 1'b1, 10'd101, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 2'd2, 4'd0, 10'd200,  8'd9,  8'd255, 32'h0,         4'b1100, 1'b0, 10'd456, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 2'd0, 4'd4, 10'd1023, 8'd0,  8'd0,   32'hA5A55A5A,  4'b1111, 1'b0, 10'd0,   1'b1, 1'b0};
`ifdef ALU_COMMIT_TRAP_EN
        vecs[7] = '{1'b0, 2'd0, 4'd3, 10'd40,   8'd0,  8'd0,   32'hDEADBEEF,  4'b0000, 1'b0, 10'd41,  1'b0, 1'b1};
`else
        vecs[7] = '{1'b0, 2'd0, 4'd3, 10'd40,   8'd0,  8'd0,   32'hDEADBEEF,  4'b0000, 1'b0, 10'd41,  1'b1, 1'b0};
`endif

        rst = 1'b1; op_vld = 1'b0; op_jmp = 1'b0; op_cond = 2'd0; op_sel = 4'd0;
        op_pc = '0; op_jt = '0; op_jf = '0; ALU_out = 32'd0;
        {eq, gt, ge, set} = 4'b0000; ALU_vld = 1'b0; commit_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        checkOutput("rst_op_rdy", 32'(op_rdy), 32'd1);
        checkOutput("rst_commit_vld", 32'(commit_vld), 32'd0);
        checkOutput("rst_A_wr_en", 32'(A_wr_en), 32'd0);
        checkOutput("rst_A_wr_data", A_wr_data, 32'd0);
        checkOutput("rst_pc_next", 32'(pc_next), 32'd0);
        checkOutput("rst_taken", 32'(taken), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_ack", 32'(ALU_ack), 32'd0);

        // A stale ALU result in IDLE must be ignored.
        ALU_vld = 1'b1; ALU_out = 32'h55;
        #1;
        checkOutput("stale_ack", 32'(ALU_ack), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("stale_commit_vld", 32'(commit_vld), 32'd0);
        checkOutput("stale_op_rdy", 32'(op_rdy), 32'd1);
        ALU_vld = 1'b0;

        for (int i = 0; i < 8; i++)
            applyStimulus(vecs[i], i % 3, (i == 0) ? 4 : i % 3);

        // Reset while waiting on the ALU drops the context; a later result is not acked.
        @(negedge clk);
        op_vld = 1'b1; op_jmp = 1'b0; op_pc = 10'd77;
        @(negedge clk);
        op_vld = 1'b0;
        checkOutput("rstwait_op_rdy", 32'(op_rdy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstwait_idle", 32'(op_rdy), 32'd1);
        ALU_vld = 1'b1; ALU_out = 32'h99;
        #1;
        checkOutput("rstwait_ack", 32'(ALU_ack), 32'd0);
        @(negedge clk);
        checkOutput("rstwait_commit", 32'(commit_vld), 32'd0);
        ALU_vld = 1'b0;

        for (int n = 0; n < 40; n++) begin
            rv.jmp   = 1'($urandom);
            rv.cond  = 2'($urandom);
            rv.sel   = 4'($urandom);
            rv.pc    = 10'($urandom);
            rv.jt    = 8'($urandom);
            rv.jf    = 8'($urandom);
            rv.alu   = $urandom;
            rv.flags = 4'($urandom);
            rv = predict(rv);
            applyStimulus(rv, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
